// File: rtl/alu_pkg.sv
// Shared ALU definitions: datapath width and the result flag bundle.
package alu_pkg;

    localparam int unsigned ALU_WIDTH = 16;

    typedef struct packed {
        logic carry;
        logic overflow;
        logic zero;
        logic neg;
    } flags_t;

endpackage

// File: rtl/cond_inv.sv
// Conditional bitwise inverter: turns B into ~B when a subtract is requested.
module cond_inv #(
    parameter int unsigned WIDTH = 16
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic             inv_i,
    output logic [WIDTH-1:0] out_o
);

    assign out_o = a_i ^ {WIDTH{inv_i}};

endmodule

// File: rtl/addsub16_pipe.sv
// Two-stage pipelined add/subtract unit with valid/ready handshakes on both sides.
// Stage 1 holds A and conditionally inverted B; stage 2 holds the sum and flags.
module addsub16_pipe
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = ALU_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_carry,
    output logic             out_overflow,
    output logic             out_zero,
    output logic             out_neg
);

    localparam int unsigned MSB = WIDTH - 1;

    logic             s1_adv;
    logic             s2_adv;
    logic [WIDTH-1:0] b_inv;
    logic [WIDTH:0]   sum_ext;

    logic             s1_valid_q, s1_valid_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] bx_q, bx_d;
    logic             cin_q, cin_d;
    logic             s2_valid_q, s2_valid_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    flags_t           flags_q, flags_d;

    cond_inv #(
        .WIDTH (WIDTH)
    ) u_cond_inv (
        .a_i   (in_b),
        .inv_i (in_sub),
        .out_o (b_inv)
    );

    // Ready depends only on pipeline state, never on in_valid.
    always_comb begin
        s2_adv   = !s2_valid_q || out_ready;
        s1_adv   = !s1_valid_q || s2_adv;
        in_ready = s1_adv;
    end

    always_comb begin
        s1_valid_d = s1_valid_q;
        a_d        = a_q;
        bx_d       = bx_q;
        cin_d      = cin_q;
        if (s1_adv) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                a_d   = in_a;
                bx_d  = b_inv;
                cin_d = in_sub;
            end
        end
    end

    // A + ~B + 1 gives A - B; the extra bit is the carry (1 = no borrow on subtract).
    always_comb begin
        sum_ext    = {1'b0, a_q} + {1'b0, bx_q} + {{WIDTH{1'b0}}, cin_q};
        s2_valid_d = s2_valid_q;
        sum_d      = sum_q;
        flags_d    = flags_q;
        if (s2_adv) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                sum_d            = sum_ext[WIDTH-1:0];
                flags_d.carry    = sum_ext[WIDTH];
                flags_d.overflow = (a_q[MSB] == bx_q[MSB]) && (sum_ext[MSB] != a_q[MSB]);
                flags_d.zero     = (sum_ext[WIDTH-1:0] == '0);
                flags_d.neg      = sum_ext[MSB];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            a_q        <= '0;
            bx_q       <= '0;
            cin_q      <= 1'b0;
            s2_valid_q <= 1'b0;
            sum_q      <= '0;
            flags_q    <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            a_q        <= a_d;
            bx_q       <= bx_d;
            cin_q      <= cin_d;
            s2_valid_q <= s2_valid_d;
            sum_q      <= sum_d;
            flags_q    <= flags_d;
        end
    end

    always_comb begin
        out_valid    = s2_valid_q;
        out_sum      = sum_q;
        out_carry    = flags_q.carry;
        out_overflow = flags_q.overflow;
        out_zero     = flags_q.zero;
        out_neg      = flags_q.neg;
    end

endmodule
